// File: rtl/logip_pkg.sv
// Shared types and defaults for the logIP capture path.
package logip_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        RD_REQ,
        RD_WAIT
    } capture_state_t;

endpackage

// File: rtl/capture_ctrl_rd_sequencer.sv
// Readback datapath: remaining-sample down-counter, descending read pointer
// and the valid/ready handshake toward the transmitter.
module rd_sequencer #(
    parameter int MEM_DEPTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 i_start,
    input  logic [MEM_DEPTH-1:0] i_addr,
    input  logic [MEM_DEPTH:0]   i_cnt,
    input  logic                 i_req,
    input  logic                 i_wait,
    input  logic                 i_abort,
    input  logic                 i_tx_ready,
    output logic                 o_mem_re,
    output logic [MEM_DEPTH-1:0] o_raddr,
    output logic                 o_tx_valid,
    output logic                 o_xfer,
    output logic                 o_last
);

    logic [MEM_DEPTH-1:0] r_raddr;
    logic [MEM_DEPTH:0]   r_cnt;
    logic                 w_xfer;

    // Strobes come straight from the phase decode so an async reset of the
    // controller state removes them without waiting for a clock.
    assign o_mem_re   = i_req  & ~i_abort;
    assign o_tx_valid = i_wait & ~i_abort;
    assign w_xfer     = o_tx_valid & i_tx_ready;
    assign o_xfer     = w_xfer;
    assign o_last     = w_xfer && (r_cnt == (MEM_DEPTH+1)'(1));
    assign o_raddr    = r_raddr;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_raddr <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_raddr <= i_addr;
            r_cnt   <= i_cnt;
        end else if (w_xfer) begin
            r_raddr <= r_raddr - 1'b1;
            r_cnt   <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer for the logIP sample memory: circular pre-trigger
// recording, post-trigger delay, then newest-first readback to the UART.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for arm; no memory traffic
// ARMED   | writing every strobe into the ring, watching for trigger
// DELAY   | trigger seen, writing the remaining post-trigger samples
// RD_REQ  | one-cycle RAM read request at the current read address
// RD_WAIT | read data presented to the transmitter until accepted
module capture_ctrl
    import logip_pkg::*;
#(
    parameter int CHLS      = 32,
    parameter int MEM_DEPTH = 10,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic                 smpl_stb_i,
    input  logic                 trg_i,
    input  logic [CNT_W-1:0]     read_cnt_i,
    input  logic [CNT_W-1:0]     dly_cnt_i,
    output logic                 mem_we_o,
    output logic [MEM_DEPTH-1:0] mem_waddr_o,
    output logic                 mem_re_o,
    output logic [MEM_DEPTH-1:0] mem_raddr_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic                 busy_o,
    output logic                 trg_seen_o
);

    localparam int CMP_W = (CNT_W > MEM_DEPTH + 1) ? CNT_W : MEM_DEPTH + 1;
    localparam logic [CMP_W-1:0] DEPTH_N = CMP_W'(1 << MEM_DEPTH);

    generate
        if (CHLS < 1 || MEM_DEPTH < 1 || CNT_W < 1) begin : g_bad_param
            $error("capture_ctrl: CHLS, MEM_DEPTH and CNT_W must be positive");
        end
    endgenerate

    capture_state_t       r_state;
    capture_state_t       w_state_nxt;
    logic [MEM_DEPTH-1:0] r_wptr;
    logic [CNT_W-1:0]     r_read_cnt;
    logic [CNT_W-1:0]     r_dly;
    logic                 r_trg_seen;

    logic                 w_wr;
    logic                 w_latch;
    logic                 w_dly_dec;
    logic                 w_trg_set;
    logic                 w_cap_done;
    logic                 w_rd_start;
    logic                 w_xfer;
    logic                 w_last;
    logic [CMP_W-1:0]     w_read_ext;
    logic [MEM_DEPTH:0]   w_rd_cnt;

    // A request larger than the ring can only return each stored sample once.
    assign w_read_ext = CMP_W'(r_read_cnt);
    assign w_rd_cnt   = (w_read_ext > DEPTH_N) ? DEPTH_N[MEM_DEPTH:0]
                                               : w_read_ext[MEM_DEPTH:0];

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_latch     = 1'b0;
        w_dly_dec   = 1'b0;
        w_trg_set   = 1'b0;
        w_cap_done  = 1'b0;
        w_rd_start  = 1'b0;

        if (abort_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm_i) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (smpl_stb_i) begin
                        w_wr = 1'b1;
                        if (trg_i) begin
                            w_trg_set = 1'b1;
                            if (r_dly == '0) begin
                                w_cap_done = 1'b1;
                            end else begin
                                w_state_nxt = DELAY;
                            end
                        end
                    end
                end
                DELAY: begin
                    if (smpl_stb_i) begin
                        w_wr      = 1'b1;
                        w_dly_dec = 1'b1;
                        if (r_dly == CNT_W'(1)) begin
                            w_cap_done = 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    w_state_nxt = RD_WAIT;
                end
                RD_WAIT: begin
                    if (w_xfer) begin
                        w_state_nxt = w_last ? IDLE : RD_REQ;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            if (w_cap_done) begin
                if (w_rd_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_rd_start  = 1'b1;
                    w_state_nxt = RD_REQ;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_read_cnt <= '0;
            r_dly      <= '0;
            r_trg_seen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_latch) begin
                r_read_cnt <= read_cnt_i;
                r_dly      <= dly_cnt_i;
            end else if (w_dly_dec) begin
                r_dly <= r_dly - 1'b1;
            end
            if (w_state_nxt == IDLE) begin
                r_trg_seen <= 1'b0;
            end else if (w_trg_set) begin
                r_trg_seen <= 1'b1;
            end
        end
    end

    // The sample being written on the final capture cycle sits at r_wptr,
    // so that is the newest entry and the first one read back.
    rd_sequencer #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_rd_seq (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .i_start    (w_rd_start),
        .i_addr     (r_wptr),
        .i_cnt      (w_rd_cnt),
        .i_req      (r_state == RD_REQ),
        .i_wait     (r_state == RD_WAIT),
        .i_abort    (abort_i),
        .i_tx_ready (tx_ready_i),
        .o_mem_re   (mem_re_o),
        .o_raddr    (mem_raddr_o),
        .o_tx_valid (tx_valid_o),
        .o_xfer     (w_xfer),
        .o_last     (w_last)
    );

    assign mem_we_o    = w_wr;
    assign mem_waddr_o = r_wptr;
    assign busy_o      = (r_state != IDLE);
    assign trg_seen_o  = r_trg_seen;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scenario bench for capture_ctrl with a 16-entry ring.
module tb_capture_ctrl;

    localparam int MD = 4;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_in = 1'b0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          smpl_stb_i = 1'b0;
    logic          trg_i = 1'b0;
    logic [CW-1:0] read_cnt_i = '0;
    logic [CW-1:0] dly_cnt_i = '0;
    logic          tx_ready_i = 1'b0;
    logic          mem_we_o, mem_re_o, tx_valid_o, busy_o, trg_seen_o;
    logic [MD-1:0] mem_waddr_o, mem_raddr_o;

    int total = 0;
    int bad = 0;
    int n_xfer;
    int exp_xfer;
    int exp_w[$];
    int exp_r[$];
    int obs_w[$];
    int obs_r[$];

    capture_ctrl #(.CHLS(32), .MEM_DEPTH(MD), .CNT_W(CW)) dut (
        .clk_i       (clk_i),
        .rst_in      (rst_in),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .smpl_stb_i  (smpl_stb_i),
        .trg_i       (trg_i),
        .read_cnt_i  (read_cnt_i),
        .dly_cnt_i   (dly_cnt_i),
        .mem_we_o    (mem_we_o),
        .mem_waddr_o (mem_waddr_o),
        .mem_re_o    (mem_re_o),
        .mem_raddr_o (mem_raddr_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .busy_o      (busy_o),
        .trg_seen_o  (trg_seen_o)
    );

    always #5 clk_i = ~clk_i;

    // Drives one cycle of inputs after the falling edge and records what the
    // DUT presents before the next rising edge.
    task automatic step(input logic stb, input logic trg, input logic rdy,
                        input logic arm, input logic abt);
        @(negedge clk_i);
        smpl_stb_i = stb;
        trg_i      = trg;
        tx_ready_i = rdy;
        arm_i      = arm;
        abort_i    = abt;
        #1;
        if (mem_we_o) obs_w.push_back(int'(mem_waddr_o));
        if (mem_re_o) obs_r.push_back(int'(mem_raddr_o));
        if (tx_valid_o && tx_ready_i) n_xfer++;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        arm_i = 0; abort_i = 0; smpl_stb_i = 0; trg_i = 0; tx_ready_i = 0;
        exp_w.delete(); exp_r.delete(); obs_w.delete(); obs_r.delete();
        n_xfer = 0; exp_xfer = 0;
        repeat (2) @(negedge clk_i);
        rst_in = 1'b1;
    endtask

    task automatic run_to_idle(input string name, input logic rdy);
        for (int k = 0; k < 60 && busy_o; k++) step(0, 0, rdy, 0, 0);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout: busy=%0b want 0", name, busy_o);
        end
    endtask

    task automatic score(input string name);
        total++;
        if (obs_w.size() != exp_w.size()) begin
            bad++;
            $display("FAIL %s_nwrites: got %0d want %0d", name, obs_w.size(), exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                total++;
                if (obs_w[i] != exp_w[i]) begin
                    bad++;
                    $display("FAIL %s_waddr[%0d]: got %0d want %0d", name, i, obs_w[i], exp_w[i]);
                end
            end
        end
        total++;
        if (obs_r.size() != exp_r.size()) begin
            bad++;
            $display("FAIL %s_nreads: got %0d want %0d", name, obs_r.size(), exp_r.size());
        end else begin
            foreach (exp_r[i]) begin
                total++;
                if (obs_r[i] != exp_r[i]) begin
                    bad++;
                    $display("FAIL %s_raddr[%0d]: got %0d want %0d", name, i, obs_r[i], exp_r[i]);
                end
            end
        end
        total++;
        if (n_xfer != exp_xfer) begin
            bad++;
            $display("FAIL %s_xfers: got %0d want %0d", name, n_xfer, exp_xfer);
        end
    endtask

    task automatic test_reset();
        logic [2*MD+4:0] outs;
        do_reset();
        #1;
        outs = {mem_we_o, mem_waddr_o, mem_re_o, mem_raddr_o, tx_valid_o, busy_o, trg_seen_o};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        for (int i = 0; i < 4; i++) step(1, i[0], 1, 0, 0);
        total++;
        if (busy_o !== 1'b0 || trg_seen_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%0b trg_seen=%0b want 0 0", busy_o, trg_seen_o);
        end
        score("reset");
    endtask

    task automatic test_basic();
        do_reset();
        read_cnt_i = 4; dly_cnt_i = 2;
        step(0, 0, 1, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            if (i <= 7) exp_w.push_back(i - 1);
            step(1, i == 5, 1, 0, 0);
            if (i == 6) begin
                total++;
                if (trg_seen_o !== 1'b1 || busy_o !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_trg_seen: trg_seen=%0b busy=%0b want 1 1", trg_seen_o, busy_o);
                end
            end
        end
        for (int k = 6; k >= 3; k--) exp_r.push_back(k);
        exp_xfer = 4;
        run_to_idle("basic", 1);
        total++;
        if (trg_seen_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_trg_clear: got %0b want 0", trg_seen_o);
        end
        score("basic");
    endtask

    task automatic test_wrap();
        do_reset();
        read_cnt_i = 40; dly_cnt_i = 0;
        step(0, 0, 1, 1, 0);
        for (int i = 0; i <= 20; i++) begin
            exp_w.push_back(i % 16);
            step(1, i == 20, 1, 0, 0);
        end
        for (int k = 0; k < 16; k++) exp_r.push_back((4 - k) & 15);
        exp_xfer = 16;
        run_to_idle("wrap", 1);
        score("wrap");
    endtask

    task automatic test_ready_stall();
        do_reset();
        read_cnt_i = 2; dly_cnt_i = 0;
        step(0, 0, 0, 1, 0);
        exp_w.push_back(0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 0, 0);
            total++;
            if (tx_valid_o !== 1'b1 || mem_raddr_o !== 4'd0 || mem_re_o !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: valid=%0b raddr=%0d re=%0b want 1 0 0",
                         c, tx_valid_o, mem_raddr_o, mem_re_o);
            end
        end
        exp_r.push_back(0);
        exp_r.push_back(15);
        exp_xfer = 2;
        step(0, 0, 1, 0, 0);
        run_to_idle("stall", 1);
        score("stall");
    endtask

    task automatic test_abort();
        do_reset();
        read_cnt_i = 3; dly_cnt_i = 5;
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            exp_w.push_back(i);
            step(1, i == 1, 1, 0, 0);
        end
        step(0, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0);
        total++;
        if (busy_o !== 1'b0 || trg_seen_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: busy=%0b trg_seen=%0b want 0 0", busy_o, trg_seen_o);
        end
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        read_cnt_i = 1; dly_cnt_i = 0;
        step(0, 0, 1, 1, 0);
        exp_w.push_back(3);
        step(1, 1, 1, 0, 0);
        exp_r.push_back(3);
        exp_xfer = 1;
        run_to_idle("abort", 1);
        score("abort");
    endtask

    task automatic test_zero_read();
        do_reset();
        read_cnt_i = 0; dly_cnt_i = 0;
        step(0, 0, 1, 1, 1);
        step(1, 1, 1, 0, 0);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL arm_abort_same: busy=%0b want 0", busy_o);
        end
        step(0, 0, 1, 1, 0);
        exp_w.push_back(0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        total++;
        if (busy_o !== 1'b0 || trg_seen_o !== 1'b0) begin
            bad++;
            $display("FAIL zero_idle: busy=%0b trg_seen=%0b want 0 0", busy_o, trg_seen_o);
        end
        repeat (3) step(0, 0, 1, 0, 0);
        score("zero");
    endtask

    task automatic test_async_reset();
        do_reset();
        read_cnt_i = 3; dly_cnt_i = 0;
        step(0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        total++;
        if (tx_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: valid=%0b want 1", tx_valid_o);
        end
        tx_ready_i = 1'b1;
        rst_in = 1'b0;
        #1;
        total++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || mem_re_o !== 1'b0 || mem_raddr_o !== 4'd0) begin
            bad++;
            $display("FAIL areset_drop: valid=%0b busy=%0b re=%0b raddr=%0d want 0 0 0 0",
                     tx_valid_o, busy_o, mem_re_o, mem_raddr_o);
        end
        @(negedge clk_i);
        rst_in = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ready_stall();
        test_abort();
        test_zero_read();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Sequencer for the logIP sample memory. Arms on host command and writes samples continuously into a circular buffer. On trigger it runs a post-trigger delay count, then reads back a programmed number of samples, newest first, to the UART transmit path using a valid/ready handshake. It sits between the trigger/sample-strobe logic, the sample RAM and the transmitter inside logIP.

Parameters:
CHLS, 32, sample width in channels; unused here except for the documented sample width; kept for consistency with logIP
MEM_DEPTH, 10, RAM address width; buffer holds 2**MEM_DEPTH samples
CNT_W, 16, width of read/delay count registers

Ports:
clk_i  in  1  system clock
rst_in  in  1  reset; asynchronous and active-low
arm_i  in  1  single-cycle pulse: start capture
abort_i  in  1  single-cycle pulse: return to idle
smpl_stb_i  in  1  sample strobe from divider; one sample per high cycle
trg_i  in  1  trigger match, qualified by smpl_stb_i
read_cnt_i  in  CNT_W  samples to return; latched on arm
dly_cnt_i  in  CNT_W  post-trigger samples; latched on arm
mem_we_o  out  1  RAM write enable
mem_waddr_o  out  MEM_DEPTH  RAM write address
mem_re_o  out  1  RAM read enable; data valid 1 cycle later
mem_raddr_o  out  MEM_DEPTH  RAM read address
tx_valid_o  out  1  RAM read data is valid for the transmitter
tx_ready_i  in  1  transmitter accepts the sample
busy_o  out  1  high in any state except IDLE
trg_seen_o  out  1  high from trigger until return to IDLE

Behaviour:
- Reset: state IDLE; wptr, counters = 0; all outputs 0.
- States: IDLE, ARMED, DELAY, RD_REQ, RD_WAIT.
- IDLE: on arm_i, latch read_cnt_i and dly_cnt_i, then go to ARMED.
- ARMED: each smpl_stb_i drives mem_we_o=1 with mem_waddr_o=wptr; wptr increments mod 2**MEM_DEPTH in the same cycle. If trg_i && smpl_stb_i, the sample is written and trg_seen_o is set. With dly=0 go to RD_REQ, else go to DELAY.
- DELAY: write on each strobe and decrement dly. The strobe that takes dly to 0 writes its sample, then the next state is RD_REQ. Exactly dly_cnt_i samples are written after the trigger sample.
- Read setup on entry to RD_REQ: raddr = wptr-1 mod 2**MEM_DEPTH (newest sample). Remaining count = min(read_cnt, 2**MEM_DEPTH). If the remaining count is 0, go directly to IDLE.
- RD_REQ: assert mem_re_o for 1 cycle at raddr, then go to RD_WAIT. tx_valid_o rises in the next cycle.
- RD_WAIT: tx_valid_o is held high until tx_ready_i. On the handshake cycle: decrement the count and decrement raddr (wrapping). Go to RD_REQ if count > 0, else to IDLE. Back-to-back throughput is 1 sample per 2 cycles minimum.
- tx_valid_o and tx_ready_i high in the same cycle counts as exactly one transfer.
- No writes occur in RD_REQ or RD_WAIT; smpl_stb_i is ignored there.
- arm_i is ignored outside IDLE.
- abort_i has priority over everything in any state: next cycle IDLE, all strobes 0, trg_seen_o cleared. wptr is retained.
- arm_i and abort_i in the same cycle: abort wins; stay IDLE.
- Async reset mid-read: outputs drop to 0 immediately, with no partial handshake completion.
- Buffer wrap in ARMED overwrites the oldest samples silently; there is no full flag.

Decomposition:
- Package logip_pkg: typedef enum capture_state_t {IDLE, ARMED, DELAY, RD_REQ, RD_WAIT}; localparam default CNT_W.
- Sub-module rd_sequencer, covering RD_REQ/RD_WAIT: the down-counter, raddr decrement and valid/ready logic, started by a start pulse with an initial address and count. It is natural but optional.

Test Plan:
- Reset then idle strobes -> no mem_we_o, busy_o=0, all outputs 0.
- arm, read=4, dly=2; 10 strobes with trg on strobe 5, tx_ready_i tied 1 -> 7 writes at addresses 0..6. Reads at 6,5,4,3, 4 tx_valid pulses, then IDLE.
- MEM_DEPTH=4; 20 pre-trigger strobes, trg, dly=0, read=40 -> write addresses wrap 15→0. Count clamps to 16; reads run from (wptr-1) downward, wrapping 0→15.
- tx_ready_i low for 5 cycles in RD_WAIT -> tx_valid_o held, raddr stable, count unchanged; completes when ready rises.
- abort_i during DELAY -> next cycle IDLE, trg_seen_o=0, no further mem_we_o. A new arm_i then works normally.
- read=0, dly=0, trg on first strobe -> one write, then IDLE with no mem_re_o.
